walk_timer: RTL

- Interval timer on the far side of the crossing control unit's timer interface.
- Consumes the controller's `tr` (timer restart) and `multiplier` outputs, and produces the `proceed` pulse the controller steps on.
- Sets phase durations: each phase lasts (multiplier+1) units; one unit is TICK_DIV clk cycles.
- Sits between the crossing control unit and the free-running system clock.

---
 rtl/crossing_pkg.sv | 7 +
 rtl/tick_prescaler.sv | 19 +
 rtl/walk_timer.sv | 46 ++++
 3 files changed

// File: rtl/crossing_pkg.sv
// crossing_pkg: shared encodings for the crossing control unit and its walk timer
// Holds multiplier encodings, timer state enum and the default units-to-cycles ratio.
package crossing_pkg;
  typedef enum logic [1:0] {MULT_1U = 2'b00, MULT_2U = 2'b01, MULT_3U = 2'b10, MULT_4U = 2'b11} mult_e;
  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} tstate_e;
  localparam int DEF_TICK_DIV = 50_000_000;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk into one-cycle unit ticks
// Ports: clk, reset (sync, active-high), clear (restart count at 0), enable (count this edge),
//        tick (combinational pulse in the cycle whose edge wraps the count from TICK_DIV-1 to 0).
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000,
  parameter int PRE_W    = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);
  logic [PRE_W-1:0] cnt_q;
  assign tick = enable && cnt_q == LAST;
  always_ff @(posedge clk)
    cnt_q <= (reset || clear || tick) ? '0 : enable ? cnt_q + PRE_W'(1) : cnt_q;
endmodule

// File: rtl/walk_timer.sv
// walk_timer: phase interval timer stepping the crossing controller via proceed
// Ports: clk, reset (sync, active-high), tr (restart timing), multiplier (phase = multiplier+1 units),
//        proceed (one-cycle expiry pulse), busy (timing in progress), units (whole units elapsed).
module walk_timer
  import crossing_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int PRE_W    = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tr,
  input  logic [1:0] multiplier,
  output logic       proceed,
  output logic       busy,
  output logic [2:0] units
);
  tstate_e    state_q, state_d;
  logic [2:0] units_q, units_d, unit_next, target;
  logic       proceed_q, proceed_d, busy_q, tick, expire;
  tick_prescaler #(.TICK_DIV(TICK_DIV), .PRE_W(PRE_W)) u_pre (
    .clk    (clk),
    .reset  (reset),
    .clear  (tr || expire),
    .enable (state_q == T_RUN && !tr),
    .tick   (tick)
  );
  // target follows the live multiplier so a late-settling or lowered value takes effect at once
  always_comb begin
    unit_next = units_q + {2'b00, tick};
    target    = {1'b0, multiplier} + 3'd1;
    expire    = !tr && state_q == T_RUN && unit_next >= target;
    state_d   = tr ? T_RUN : expire ? T_DONE : state_q;
    units_d   = tr ? 3'd0 : state_q == T_RUN ? unit_next : units_q;
    proceed_d = expire;
  end
  always_ff @(posedge clk) begin
    state_q   <= reset ? T_IDLE : state_d;
    units_q   <= reset ? 3'd0 : units_d;
    proceed_q <= !reset && proceed_d;
    busy_q    <= !reset && state_d == T_RUN;
  end
  assign proceed = proceed_q;
  assign busy    = busy_q;
  assign units   = units_q;
endmodule
